// File: rtl/activation_skew_buffer.sv
// rtl/activation_skew_buffer.sv - Row skew stage feeding the systolic array row inputs.
// Row i is delayed by i advancing cycles. The block adds a handshake, a drain tracker and a BIST bypass.
module activation_skew_buffer #(
    parameter int SYSTOLIC_SIZE    = 8,
    parameter int ACTIVATION_WIDTH = 8
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      test_mode,
    input  logic                                      stall,
    input  logic                                      flush,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] act_in_flat,
    input  logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] test_in_flat,
    input  logic                                      test_valid,
    input  logic [SYSTOLIC_SIZE-1:0]                  row_disable,
    output logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] act_out_flat,
    output logic [SYSTOLIC_SIZE-1:0]                  act_valid_out,
    output logic                                      busy,
    output logic                                      drain_done
);
    localparam int W     = ACTIVATION_WIDTH;
    localparam int CNT_W = $clog2(SYSTOLIC_SIZE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               done_next;
    logic               accept;

    assign in_ready = rst_n & ~stall & ~flush & ~test_mode;
    assign accept   = in_valid & in_ready;

    for (genvar i = 0; i < SYSTOLIC_SIZE; i++) begin : g_row
        logic [W-1:0] row_data;
        logic         row_valid;

        if (i == 0) begin : g_direct
            assign row_data  = act_in_flat[W-1:0];
            assign row_valid = accept;
        end else begin : g_chain
            logic [W-1:0] chain_data [i];
            logic [i-1:0] chain_valid;

            // Idle cycles load zeros so an undriven row presents 0 to the array.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    chain_valid <= '0;
                    for (int s = 0; s < i; s++) chain_data[s] <= '0;
                end else if (flush || test_mode) begin
                    chain_valid <= '0;
                    for (int s = 0; s < i; s++) chain_data[s] <= '0;
                end else if (!stall) begin
                    chain_valid[0] <= accept;
                    chain_data[0]  <= accept ? act_in_flat[i*W +: W] : '0;
                    for (int s = 1; s < i; s++) begin
                        chain_valid[s] <= chain_valid[s-1];
                        chain_data[s]  <= chain_data[s-1];
                    end
                end
            end

            assign row_data  = chain_data[i-1];
            assign row_valid = chain_valid[i-1] & ~stall;
        end

        assign act_out_flat[i*W +: W] = row_disable[i] ? '0 :
                                        (test_mode ? test_in_flat[i*W +: W] : row_data);
        assign act_valid_out[i]       = test_mode ? test_valid : row_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            drain_done <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            drain_done <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        done_next  = 1'b0;
        if (flush || test_mode) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else if (!stall) begin
            case (state)
                IDLE: begin
                    if (accept) state_next = STREAM;
                end
                STREAM: begin
                    if (!accept) begin
                        if (SYSTOLIC_SIZE == 2) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                            done_next  = 1'b1;
                        end else begin
                            state_next = DRAIN;
                            cnt_next   = CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        state_next = STREAM;
                        cnt_next   = '0;
                    end else if (cnt == CNT_W'(SYSTOLIC_SIZE - 2)) begin
                        // This increment makes cnt reach SYSTOLIC_SIZE-1: the last row has emitted.
                        state_next = IDLE;
                        cnt_next   = '0;
                        done_next  = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
